// File: rtl/frogger_pkg.sv
// Shared playfield constants and home-row state encoding for the Frogger design.
package frogger_pkg;

  localparam int NUM_PADS = 5;
  localparam int HOME_Y   = 20;

  // Centre X of each home pad, left to right.
  localparam logic [9:0] PAD_X [NUM_PADS] = '{10'd76, 10'd191, 10'd309, 10'd425, 10'd541};

  typedef enum logic [1:0] {
    PLAY,
    CELEBRATE,
    DEATH,
    CLEAR
  } home_state_t;

endpackage

// File: rtl/pad_hit_decode.sv
// Combinational decode of the frog's X position into a home-pad hit and pad index.
module pad_hit_decode
  import frogger_pkg::*;
#(
  parameter int TOL = 16
) (
  input  logic [9:0] frog_x,
  output logic       hit,
  output logic [2:0] idx
);

  logic signed [10:0] diff;

  // Pad windows never overlap, so the last match in the loop is the only match.
  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    hit  = 1'b0;
    idx  = 3'd0;
    diff = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      diff = signed'({1'b0, frog_x}) - signed'({1'b0, PAD_X[i]});
      if (int'(diff) >= -TOL && int'(diff) <= TOL) begin
        hit = 1'b1;
        idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/home_pad_ctrl.sv
// Home-row scheduler: judges arrivals against the pads, tracks occupancy and
// sequences the celebrate / death / level-clear phases once per video frame.
module home_pad_ctrl
  import frogger_pkg::*;
#(
  parameter int TOL              = 16,
  parameter int CELEBRATE_FRAMES = 60,
  parameter int DEATH_FRAMES     = 45,
  parameter int CLEAR_FRAMES     = 120
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [9:0] frog_x,
  input  logic       arrive,
  output logic [4:0] pad_filled,
  output int         win,
  output logic       frog_home,
  output logic       frog_kill,
  output logic       respawn,
  output logic       level_clear,
  output logic [3:0] level
);

  localparam int CNT_W = 16;

  home_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [4:0]       pad_filled_n;
  int               win_n;
  logic [3:0]       level_n;
  logic             frog_home_n, frog_kill_n, respawn_n, level_clear_n;
  logic             hit;
  logic [2:0]       idx;

  pad_hit_decode #(.TOL(TOL)) u_decode (
    .frog_x (frog_x),
    .hit    (hit),
    .idx    (idx)
  );

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    pad_filled_n = pad_filled;
    win_n        = win;
    level_n      = level;
    frog_home_n  = 1'b0;
    frog_kill_n  = 1'b0;
    respawn_n    = 1'b0;

    unique case (state)
      PLAY: begin
        if (arrive) begin
          if (hit && !pad_filled[idx]) begin
            pad_filled_n[idx] = 1'b1;
            win_n             = int'(idx) + 1;
            frog_home_n       = 1'b1;
            cnt_n             = CNT_W'(CELEBRATE_FRAMES - 1);
            state_n           = CELEBRATE;
          end else begin
            frog_kill_n = 1'b1;
            cnt_n       = CNT_W'(DEATH_FRAMES - 1);
            state_n     = DEATH;
          end
        end
      end
      CELEBRATE: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (pad_filled == 5'b11111) begin
          cnt_n   = CNT_W'(CLEAR_FRAMES - 1);
          state_n = CLEAR;
        end else begin
          win_n     = 0;
          respawn_n = 1'b1;
          state_n   = PLAY;
        end
      end
      DEATH: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          respawn_n = 1'b1;
          state_n   = PLAY;
        end
      end
      CLEAR: begin
        // win keeps the fifth pad's code so the icon stays lit through the clear.
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          pad_filled_n = '0;
          win_n        = 0;
          level_n      = (level == 4'd15) ? level : level + 4'd1;
          respawn_n    = 1'b1;
          state_n      = PLAY;
        end
      end
      default: state_n = PLAY;
    endcase

    level_clear_n = (state_n == CLEAR);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= PLAY;
      cnt         <= '0;
      pad_filled  <= '0;
      win         <= 0;
      level       <= '0;
      frog_home   <= 1'b0;
      frog_kill   <= 1'b0;
      respawn     <= 1'b0;
      level_clear <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      state       <= state_n;
      cnt         <= cnt_n;
      pad_filled  <= pad_filled_n;
      win         <= win_n;
      level       <= level_n;
      frog_home   <= frog_home_n;
      frog_kill   <= frog_kill_n;
      respawn     <= respawn_n;
      level_clear <= level_clear_n;
    end
  end

endmodule

// File: tb/tb_home_pad_ctrl.sv
// Directed self-checking bench for home_pad_ctrl with hand-computed expectations.
module tb_home_pad_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [9:0] frog_x;
  logic       arrive;
  logic [4:0] pad_filled;
  int         win;
  logic       frog_home, frog_kill, respawn, level_clear;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;

  home_pad_ctrl #(
    .TOL(16), .CELEBRATE_FRAMES(60), .DEATH_FRAMES(45), .CLEAR_FRAMES(120)
  ) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .frog_x      (frog_x),
    .arrive      (arrive),
    .pad_filled  (pad_filled),
    .win         (win),
    .frog_home   (frog_home),
    .frog_kill   (frog_kill),
    .respawn     (respawn),
    .level_clear (level_clear),
    .level       (level)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one frame and settle just after the edge.
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_arrive(input int x);
    frog_x = 10'(x);
    arrive = 1'b1;
    step();
    arrive = 1'b0;
  endtask

  // Landing or kill just happened; respawn must appear exactly `frames` edges later.
  task automatic expect_respawn(input int frames, input string tag);
    run(frames - 1);
    check({tag, "_no_early_respawn"}, int'(respawn), 0);
    step();
    check({tag, "_respawn"}, int'(respawn), 1);
    check({tag, "_win_cleared"}, win, 0);
    step();
    check({tag, "_respawn_one_frame"}, int'(respawn), 0);
  endtask

  task automatic good_land(input int x, input int exp_win, input int exp_pads, input string tag);
    pulse_arrive(x);
    check({tag, "_home"}, int'(frog_home), 1);
    check({tag, "_kill"}, int'(frog_kill), 0);
    check({tag, "_win"}, win, exp_win);
    check({tag, "_pads"}, int'(pad_filled), exp_pads);
  endtask

  task automatic bad_land(input int x, input int exp_pads, input string tag);
    pulse_arrive(x);
    check({tag, "_kill"}, int'(frog_kill), 1);
    check({tag, "_home"}, int'(frog_home), 0);
    check({tag, "_pads"}, int'(pad_filled), exp_pads);
    step();
    check({tag, "_kill_one_frame"}, int'(frog_kill), 0);
    expect_respawn(44, tag);
  endtask

  initial begin
    Reset  = 1'b1;
    frog_x = '0;
    arrive = 1'b0;
    #12;
    check("rst_pads", int'(pad_filled), 0);
    check("rst_win", win, 0);
    check("rst_level", int'(level), 0);
    check("rst_clear", int'(level_clear), 0);
    check("rst_pulses", int'({frog_home, frog_kill, respawn}), 0);
    Reset = 1'b0;
    step();

    // First landing on pad 2, with an ignored arrive during CELEBRATE.
    good_land(191, 2, 5'b00010, "pad2");
    step();
    check("pad2_home_one_frame", int'(frog_home), 0);
    run(10);
    pulse_arrive(309);
    check("celebrate_arrive_kill", int'(frog_kill), 0);
    check("celebrate_arrive_home", int'(frog_home), 0);
    check("celebrate_arrive_pads", int'(pad_filled), 5'b00010);
    check("celebrate_arrive_win", win, 2);
    expect_respawn(60 - 12, "pad2");

    // Misses: already-filled pad, gap between pads, far left edge.
    bad_land(195, 5'b00010, "refill_pad2");
    bad_land(130, 5'b00010, "gap130");
    bad_land(0, 5'b00010, "x0");

    // Window boundaries: exactly TOL away hits, TOL+1 misses.
    good_land(92, 1, 5'b00011, "pad1_edge");
    expect_respawn(60, "pad1_edge");
    bad_land(326, 5'b00011, "pad3_outside");
    good_land(293, 3, 5'b00111, "pad3_edge");
    expect_respawn(60, "pad3_edge");
    good_land(441, 4, 5'b01111, "pad4_edge");
    expect_respawn(60, "pad4_edge");
    good_land(525, 5, 5'b11111, "pad5_edge");

    // Fifth landing: 60 frames celebrate, then 120 frames of CLEAR.
    run(59);
    check("pre_clear_flag", int'(level_clear), 0);
    step();
    check("clear_flag", int'(level_clear), 1);
    check("clear_win_held", win, 5);
    check("clear_no_respawn", int'(respawn), 0);
    pulse_arrive(76);
    check("clear_arrive_kill", int'(frog_kill), 0);
    check("clear_arrive_flag", int'(level_clear), 1);
    check("clear_arrive_pads", int'(pad_filled), 5'b11111);
    run(118);
    check("clear_last_frame", int'(level_clear), 1);
    check("clear_last_no_respawn", int'(respawn), 0);
    step();
    check("clear_done_flag", int'(level_clear), 0);
    check("clear_done_respawn", int'(respawn), 1);
    check("clear_done_pads", int'(pad_filled), 0);
    check("clear_done_win", win, 0);
    check("clear_done_level", int'(level), 1);
    step();

    // Second round: refill and reset asynchronously in the middle of CLEAR.
    good_land(76, 1, 5'b00001, "r2_pad1");
    expect_respawn(60, "r2_pad1");
    good_land(191, 2, 5'b00011, "r2_pad2");
    expect_respawn(60, "r2_pad2");
    good_land(309, 3, 5'b00111, "r2_pad3");
    expect_respawn(60, "r2_pad3");
    good_land(425, 4, 5'b01111, "r2_pad4");
    expect_respawn(60, "r2_pad4");
    good_land(541, 5, 5'b11111, "r2_pad5");
    run(60 + 30);
    check("r2_in_clear", int'(level_clear), 1);
    check("r2_level_before_reset", int'(level), 1);
    #2 Reset = 1'b1;
    #1;
    check("midrst_pads", int'(pad_filled), 0);
    check("midrst_win", win, 0);
    check("midrst_clear", int'(level_clear), 0);
    check("midrst_level", int'(level), 0);
    check("midrst_pulses", int'({frog_home, frog_kill, respawn}), 0);
    Reset = 1'b0;
    run(100);
    check("post_rst_clear", int'(level_clear), 0);
    check("post_rst_level", int'(level), 0);
    check("post_rst_respawn", int'(respawn), 0);
    good_land(425, 4, 5'b01000, "post_rst_land");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
